clock_divider_ctrl: RTL and testbench
=====================================

Name: clock_divider_ctrl

Overview:
- Runtime-programmable clock divider and sequencer for the acquisition timing chain (ADC and trigger sampling clocks) derived from the 50 MHz global clock.
- Handles start/stop and divide-ratio changes. New ratios are accepted over a valid/ready handshake and applied only at a period boundary, so the output never has a runt pulse.
- Also produces one-cycle rise and fall strobes that downstream logic uses as clock enables.

Parameters:
- DIV_W, 16: width of the divide-ratio registers.
- DEFAULT_DIV, 5: active ratio after reset; 50 MHz / 5 = 10 MHz.

Ports:
- global_clock, input, 1: single system clock.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: level. High runs the divider; low stops it at the end of the current period.
- div_in, input, DIV_W: requested divide ratio N.
- div_valid, input, 1: div_in is offered.
- div_ready, output, 1: controller can accept a new ratio.
- div_err, output, 1: one-cycle pulse when a ratio below 2 is rejected.
- active_div, output, DIV_W: ratio currently in force.
- clock, output, 1: divided clock, registered.
- rise_stb, output, 1: one-cycle pulse on the edge where clock goes 0 to 1.
- fall_stb, output, 1: one-cycle pulse on the edge where clock goes 1 to 0.
- busy, output, 1: high in RUN or DRAIN.

Behaviour:
- Reset (asynchronous) sets:
  - state = IDLE, cnt = 0, pending = 0
  - clock = 0, rise_stb = 0, fall_stb = 0, div_err = 0, busy = 0
  - active_div = DEFAULT_DIV, div_ready = 1
  - Reset asserted mid-period forces clock low immediately with no completion.
- Waveform for ratio N:
  - HI = N - floor(N/2) cycles high, then floor(N/2) cycles low.
  - Example: N=5 gives 3 high, 2 low. N=2 gives 1 high, 1 low.
- Counter cnt runs 0..N-1. A boundary is an edge in RUN or DRAIN with cnt == N-1.
- IDLE:
  - clock = 0.
  - If enable = 1, the next edge enters RUN with cnt = 0, clock = 1, rise_stb = 1.
- RUN, per edge:
  - At a boundary: cnt <= 0, clock <= 1, rise_stb pulses.
  - Otherwise: cnt <= cnt+1, clock <= (cnt+1 < HI). fall_stb pulses when this edge takes clock from 1 to 0.
- RUN, enable low: the state moves to DRAIN on the next edge. The waveform continues unchanged.
- DRAIN:
  - Waveform continues as in RUN.
  - At the boundary: go to IDLE, cnt = 0, clock = 0, no rise_stb.
  - If enable returns high before the boundary, go back to RUN with no disturbance to the waveform.
- Ratio handshake: a transfer occurs on an edge where div_valid & div_ready.
  - div_in < 2: rejected. div_err pulses on the next cycle. active_div and pending are unchanged.
  - In IDLE: active_div <= div_in immediately. div_ready stays 1.
  - In RUN or DRAIN: the value goes to the pending register, pending <= 1, div_ready <= 0.
- Applying a pending ratio:
  - Applied at the first boundary strictly after acceptance: active_div <= pending value, pending <= 0, div_ready <= 1.
  - A value accepted on a boundary edge waits for the following boundary.
  - If a boundary drains to IDLE, the pending value is applied on that same edge.
- HI is always computed from active_div. A ratio change never alters a period already in progress.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN
- Defined:
  - Adds output period_cnt [31:0], reset to 0.
  - Increments on every rise_stb and wraps at 2^32-1 to 0.
  - Adds input period_clr, which has priority over the increment.
  - The count is retained across IDLE.
- Undefined: period_cnt and period_clr do not exist. Core behaviour is identical.

Test Plan:
- Reset, then enable=1 held:
  - clock shows 3 cycles high, 2 low, repeating (N=5).
  - rise_stb appears every 5 cycles and fall_stb 3 cycles after each rise_stb.
  - active_div = 5.
- While running, offer div_in=8 in mid-period:
  - div_ready drops.
  - The current period completes as 3/2.
  - The next period is 4 high / 4 low, and div_ready returns on the boundary.
- Offer div_in=1 and then div_in=0:
  - div_err pulses once for each.
  - active_div and the waveform are unchanged; div_ready stays 1.
- Drop enable at cnt=1 with N=5:
  - The period finishes; clock is low from the boundary onward and busy falls.
  - No extra rise_stb.
  - Re-raising enable at cnt=3 instead keeps the waveform uninterrupted.
- Assert reset asynchronously while clock = 1:
  - clock, strobes and busy go 0 immediately, with no dependence on a global_clock edge.
  - active_div returns to 5.
- With CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN defined:
  - After 10 periods, period_cnt = 10.
  - period_clr coincident with rise_stb gives 0.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// rtl/clock_divider_ctrl.sv - runtime-programmable clock divider with boundary-aligned ratio changes
// Optional period counter (period_cnt/period_clr) enabled by CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN.
module clock_divider_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             global_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic [DIV_W-1:0] active_div,
  output logic             clock,
  output logic             rise_stb,
  output logic             fall_stb,
`ifdef CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN
  input  logic             period_clr,
  output logic [31:0]      period_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             pending, pending_nxt;
  logic [DIV_W-1:0] active_nxt;
  logic             clock_nxt, rise_nxt, fall_nxt, err_nxt, ready_nxt, busy_nxt;

  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] cnt_inc;
  logic             boundary;
  logic             xfer;

  // High phase is the longer half, so odd ratios spend the extra cycle high.
  assign hi       = active_div - (active_div >> 1);
  assign cnt_inc  = cnt + DIV_W'(1);
  assign boundary = (state != IDLE) && (cnt == active_div - DIV_W'(1));
  assign xfer     = div_valid && div_ready;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clock_nxt    = clock;
    rise_nxt     = 1'b0;
    fall_nxt     = 1'b0;
    err_nxt      = 1'b0;
    active_nxt   = active_div;
    ready_nxt    = div_ready;
    pending_nxt  = pending;
    pend_div_nxt = pend_div;

    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        clock_nxt = 1'b0;
        // A ratio captured on the draining boundary edge lands here; apply it now.
        if (pending) begin
          active_nxt  = pend_div;
          pending_nxt = 1'b0;
          ready_nxt   = 1'b1;
        end
        if (enable) begin
          state_nxt = RUN;
          clock_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (boundary) begin
          cnt_nxt = '0;
          if (pending) begin
            active_nxt  = pend_div;
            pending_nxt = 1'b0;
            ready_nxt   = 1'b1;
          end
          if (state == DRAIN && !enable) begin
            state_nxt = IDLE;
            clock_nxt = 1'b0;
          end else begin
            state_nxt = enable ? RUN : DRAIN;
            clock_nxt = 1'b1;
            rise_nxt  = 1'b1;
          end
        end else begin
          state_nxt = enable ? RUN : DRAIN;
          cnt_nxt   = cnt_inc;
          clock_nxt = (cnt_inc < hi);
          fall_nxt  = clock && !(cnt_inc < hi);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        clock_nxt = 1'b0;
      end
    endcase

    // div_ready is low whenever a ratio is pending, so this never collides with an apply.
    if (xfer) begin
      if (div_in < DIV_W'(2)) begin
        err_nxt = 1'b1;
      end else if (state == IDLE) begin
        active_nxt = div_in;
      end else begin
        pend_div_nxt = div_in;
        pending_nxt  = 1'b1;
        ready_nxt    = 1'b0;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge global_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      pend_div   <= '0;
      clock      <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      div_err    <= 1'b0;
      busy       <= 1'b0;
      active_div <= DIV_W'(DEFAULT_DIV);
      div_ready  <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      pend_div   <= pend_div_nxt;
      clock      <= clock_nxt;
      rise_stb   <= rise_nxt;
      fall_stb   <= fall_nxt;
      div_err    <= err_nxt;
      busy       <= busy_nxt;
      active_div <= active_nxt;
      div_ready  <= ready_nxt;
    end
  end

`ifdef CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN
  always_ff @(posedge global_clock or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (period_clr) begin
      period_cnt <= '0;
    end else if (rise_stb) begin
      period_cnt <= period_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb/tb_clock_divider_ctrl.sv - scoreboard bench for clock_divider_ctrl
// Expected strobe events are queued by the stimulus and popped by a negedge monitor.
module tb_clock_divider_ctrl;

  logic        global_clock = 1'b0;
  logic        reset        = 1'b1;
  logic        enable       = 1'b0;
  logic [15:0] div_in       = 16'd0;
  logic        div_valid    = 1'b0;
  logic        div_ready;
  logic        div_err;
  logic [15:0] active_div;
  logic        clock;
  logic        rise_stb;
  logic        fall_stb;
  logic        busy;
`ifdef CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN
  logic        period_clr = 1'b0;
  logic [31:0] period_cnt;
`endif

  clock_divider_ctrl #(.DIV_W(16), .DEFAULT_DIV(5)) dut (
    .global_clock (global_clock),
    .reset        (reset),
    .enable       (enable),
    .div_in       (div_in),
    .div_valid    (div_valid),
    .div_ready    (div_ready),
    .div_err      (div_err),
    .active_div   (active_div),
    .clock        (clock),
    .rise_stb     (rise_stb),
    .fall_stb     (fall_stb),
`ifdef CLOCK_DIVIDER_CTRL_PERIOD_CNT_EN
    .period_clr   (period_clr),
    .period_cnt   (period_cnt),
`endif
    .busy         (busy)
  );

  always #10 global_clock = ~global_clock;

  int cyc = 0;
  always @(posedge global_clock) cyc <= cyc + 1;

  typedef struct {
    byte kind;
    int  at;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input byte k, input int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic got(input byte k);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %c at cycle %0d, expected none", k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.at != cyc) begin
        n_fail++;
        $display("FAIL event_order: got %c at cycle %0d, expected %c at cycle %0d", k, cyc, e.kind, e.at);
      end
    end
  endtask

  always @(negedge global_clock) begin
    if (rise_stb) got("R");
    if (fall_stb) got("F");
    if (div_err)  got("E");
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge global_clock);
  endtask

  int e0;
  int e2;

  initial begin
    wait_to(2);
    reset = 1'b0;
    chk("rst_clock", clock, 0);
    chk("rst_rise", rise_stb, 0);
    chk("rst_fall", fall_stb, 0);
    chk("rst_err", div_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_div", active_div, 5);
    chk("rst_div_ready", div_ready, 1);
    wait_to(4);

    // N=5 free run: 3 high, 2 low.
    e0 = cyc + 1;
    enable = 1'b1;
    push_ev("R", e0);      push_ev("F", e0 + 3);
    push_ev("R", e0 + 5);  push_ev("F", e0 + 8);
    push_ev("R", e0 + 10);
    for (int i = 0; i < 5; i++) begin
      wait_to(e0 + i);
      chk("n5_clock_level", clock, (i < 3) ? 1 : 0);
    end
    chk("n5_busy", busy, 1);
    chk("n5_active_div", active_div, 5);

    // Mid-period ratio change to 8; takes effect at the next boundary.
    wait_to(e0 + 11);
    div_in = 16'd8; div_valid = 1'b1;
    push_ev("F", e0 + 13); push_ev("R", e0 + 15);
    push_ev("F", e0 + 19); push_ev("R", e0 + 23);
    wait_to(e0 + 12);
    div_valid = 1'b0;
    chk("pend_ready_low", div_ready, 0);
    chk("pend_active_old", active_div, 5);
    wait_to(e0 + 14);
    chk("pend_still_low", div_ready, 0);
    wait_to(e0 + 15);
    chk("apply_ready_high", div_ready, 1);
    chk("apply_active_8", active_div, 8);
    wait_to(e0 + 18);
    chk("n8_fourth_high", clock, 1);
    wait_to(e0 + 19);
    chk("n8_first_low", clock, 0);

    // Rejected ratios 1 and 0.
    wait_to(e0 + 23);
    div_in = 16'd1; div_valid = 1'b1;
    push_ev("E", e0 + 24); push_ev("E", e0 + 25);
    push_ev("F", e0 + 27); push_ev("R", e0 + 31);
    wait_to(e0 + 24);
    div_in = 16'd0;
    wait_to(e0 + 25);
    div_valid = 1'b0;
    chk("rej_active", active_div, 8);
    chk("rej_ready", div_ready, 1);

    // Back to N=5, then drop enable at cnt=1 and drain.
    wait_to(e0 + 31);
    div_in = 16'd5; div_valid = 1'b1;
    push_ev("F", e0 + 35); push_ev("R", e0 + 39);
    push_ev("F", e0 + 42); push_ev("R", e0 + 44);
    push_ev("F", e0 + 47);
    wait_to(e0 + 32);
    div_valid = 1'b0;
    wait_to(e0 + 39);
    chk("back5_active", active_div, 5);
    wait_to(e0 + 45);
    enable = 1'b0;
    wait_to(e0 + 48);
    chk("drain_busy", busy, 1);
    wait_to(e0 + 49);
    chk("drain_done_busy", busy, 0);
    chk("drain_done_clock", clock, 0);

    // IDLE ratio write is immediate.
    wait_to(e0 + 50);
    div_in = 16'd6; div_valid = 1'b1;
    wait_to(e0 + 51);
    div_valid = 1'b0;
    chk("idle_active_6", active_div, 6);
    chk("idle_ready", div_ready, 1);
    chk("idle_clock", clock, 0);

    // N=6 run with a drain cancelled at cnt=3.
    wait_to(e0 + 52);
    e2 = cyc + 1;
    enable = 1'b1;
    push_ev("R", e2);      push_ev("F", e2 + 3);
    push_ev("R", e2 + 6);  push_ev("F", e2 + 9);
    push_ev("R", e2 + 12);
    wait_to(e2 + 6);
    enable = 1'b0;
    for (int i = 7; i <= 11; i++) begin
      wait_to(e2 + i);
      if (i == 9) enable = 1'b1;
      chk("cancel_busy", busy, 1);
    end
    wait_to(e2 + 12);
    chk("cancel_clock_high", clock, 1);

    // Asynchronous reset while clock is high.
    #2;
    reset = 1'b1;
    #1;
    chk("areset_clock", clock, 0);
    chk("areset_rise", rise_stb, 0);
    chk("areset_busy", busy, 0);
    chk("areset_active_div", active_div, 5);
    chk("areset_ready", div_ready, 1);
    enable = 1'b0;
    wait_to(cyc + 2);
    reset = 1'b0;
    wait_to(cyc + 6);
    chk("post_reset_clock", clock, 0);
    chk("post_reset_busy", busy, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
